// File: rtl/ex1_pkg.sv
// Shared types, widths and the reference power/product rule for the ex1 result path.
package ex1_pkg;

  localparam int unsigned X_W = 2;
  localparam int unsigned O_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  // x==y selects x**y (0**0 = 1), otherwise x*y; both truncated to O_W bits.
  function automatic logic [O_W-1:0] exp_result(input logic [X_W-1:0] x,
                                                 input logic [X_W-1:0] y);
    logic [O_W-1:0] r;
    if (x == y) begin
      r = O_W'(1);
      for (int i = 0; i < (1 << X_W) - 1; i++) begin
        if (i < int'(y)) r = r * O_W'(x);
      end
    end else begin
      r = O_W'(x) * O_W'(y);
    end
    return r;
  endfunction

endpackage

// File: rtl/ex1_ref_model.sv
// Combinational expected-result generator used by the optional sample checker.
module ex1_ref_model
  import ex1_pkg::*;
(
  input  logic [X_W-1:0] x_i,
  input  logic [X_W-1:0] y_i,
  output logic [O_W-1:0] exp_o
);

  assign exp_o = exp_result(x_i, y_i);

endmodule

// File: rtl/ex1_result_acc.sv
// Frame accumulator for x/y power-or-product results: sum, max and power-mode count.
// Defining EX1_ACC_CHECK_EN adds mismatch_cnt, counting samples whose o disagrees with x/y.
module ex1_result_acc
  import ex1_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 16,
  parameter int unsigned SUM_W       = 10,
  parameter int unsigned CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  input  logic [X_W-1:0]   in_y,
  input  logic [O_W-1:0]   in_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum_o,
  output logic             sum_ovf,
  output logic [O_W-1:0]   max_o,
  output logic [CNT_W-1:0] pow_cnt,
`ifdef EX1_ACC_CHECK_EN
  output logic [CNT_W-1:0] mismatch_cnt,
`endif
  output logic             busy
);

  state_e state_q, state_d;

  logic [SUM_W-1:0] sum_q;
  logic             ovf_q;
  logic [O_W-1:0]   max_q;
  logic [CNT_W-1:0] pow_q;
  logic [CNT_W-1:0] cnt_q;

  logic             xfer;
  logic             last;
  logic             clear;
  logic [SUM_W:0]   sum_ext;

  assign xfer    = in_valid & in_ready;
  assign last    = xfer && (cnt_q == CNT_W'(NUM_SAMPLES - 1));
  assign clear   = (state_q == StIdle) && start;
  assign sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(in_o);

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAccum;
      StAccum: if (last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StAccum: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StDone: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Accumulators hold through DONE and IDLE so the last summary stays readable until start.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
      max_q <= '0;
      pow_q <= '0;
      cnt_q <= '0;
    end else if (xfer) begin
      sum_q <= sum_ext[SUM_W-1:0];
      ovf_q <= ovf_q | sum_ext[SUM_W];
      if (in_o > max_q) max_q <= in_o;
      pow_q <= pow_q + CNT_W'(in_x == in_y);
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sum_o   = sum_q;
  assign sum_ovf = ovf_q;
  assign max_o   = max_q;
  assign pow_cnt = pow_q;

`ifdef EX1_ACC_CHECK_EN
  logic [O_W-1:0]   exp_o;
  logic [CNT_W-1:0] mis_q;

  ex1_ref_model u_ref_model (
    .x_i   (in_x),
    .y_i   (in_y),
    .exp_o (exp_o)
  );

  always_ff @(posedge clk) begin
    if (rst || clear)              mis_q <= '0;
    else if (xfer && exp_o != in_o) mis_q <= mis_q + CNT_W'(1);
  end

  assign mismatch_cnt = mis_q;
`endif

endmodule

// File: tb/tb_ex1_result_acc.sv
// Randomised self-checking bench for ex1_result_acc against a frame-level arithmetic model.
module tb_ex1_result_acc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_x = '0;
  logic [1:0] in_y = '0;
  logic [4:0] in_o = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] sum_o;
  logic       sum_ovf;
  logic [4:0] max_o;
  logic [4:0] pow_cnt;
  logic [4:0] mismatch_cnt;
  logic       busy;

  // Small instance for the overflow scenario.
  logic       o_start = 1'b0;
  logic       o_in_valid = 1'b0;
  logic       o_in_ready;
  logic [1:0] o_x = '0;
  logic [1:0] o_y = '0;
  logic [4:0] o_o = '0;
  logic       o_out_valid;
  logic       o_out_ready = 1'b0;
  logic [4:0] o_sum;
  logic       o_ovf;
  logic [4:0] o_max;
  logic [2:0] o_pow;
  logic [2:0] o_mis;
  logic       o_busy;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int sx[16];
  int sy[16];
  int so[16];

  always #5 clk = ~clk;

  ex1_result_acc dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_o         (in_o),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sum_o        (sum_o),
    .sum_ovf      (sum_ovf),
    .max_o        (max_o),
    .pow_cnt      (pow_cnt),
`ifdef EX1_ACC_CHECK_EN
    .mismatch_cnt (mismatch_cnt),
`endif
    .busy         (busy)
  );

  ex1_result_acc #(
    .NUM_SAMPLES (4),
    .SUM_W       (5),
    .CNT_W       (3)
  ) dut_ovf (
    .clk          (clk),
    .rst          (rst),
    .start        (o_start),
    .in_valid     (o_in_valid),
    .in_ready     (o_in_ready),
    .in_x         (o_x),
    .in_y         (o_y),
    .in_o         (o_o),
    .out_valid    (o_out_valid),
    .out_ready    (o_out_ready),
    .sum_o        (o_sum),
    .sum_ovf      (o_ovf),
    .max_o        (o_max),
    .pow_cnt      (o_pow),
`ifdef EX1_ACC_CHECK_EN
    .mismatch_cnt (o_mis),
`endif
    .busy         (o_busy)
  );

`ifndef EX1_ACC_CHECK_EN
  assign mismatch_cnt = '0;
  assign o_mis = '0;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  // Frame-level reference: plain integer arithmetic over the sample list.
  function automatic void model(input int n, input int sw, output int e_sum, output int e_ovf,
                                output int e_max, output int e_pow, output int e_mis);
    int total = 0;
    int r;
    e_max = 0; e_pow = 0; e_mis = 0;
    for (int i = 0; i < n; i++) begin
      total += so[i];
      if (so[i] > e_max) e_max = so[i];
      if (sx[i] == sy[i]) e_pow++;
      r = (sx[i] == sy[i]) ? sx[i] ** sy[i] : sx[i] * sy[i];
      if ((r % 32) != so[i]) e_mis++;
    end
    e_sum = total % (1 << sw);
    e_ovf = (total >= (1 << sw)) ? 1 : 0;
  endfunction

  function automatic void fill_sweep();
    for (int i = 0; i < 16; i++) begin
      sx[i] = i / 4;
      sy[i] = i % 4;
      so[i] = ((sx[i] == sy[i]) ? sx[i] ** sy[i] : sx[i] * sy[i]) % 32;
    end
  endfunction

  // Drives start then nxfer samples; returns at the negedge right after the last transfer.
  task automatic send_frame(input int nxfer, input int gap_mode, output bit timed_out,
                            output bit early_valid);
    int idx = 0;
    int cyc = 0;
    bit v;
    timed_out = 0;
    early_valid = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < nxfer && !timed_out) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_x = 2'(sx[idx]);
      in_y = 2'(sy[idx]);
      in_o = 5'(so[idx]);
      if (out_valid) early_valid = 1;
      if (v && in_ready) idx++;
      @(negedge clk);
      cyc++;
      if (cyc > 400) timed_out = 1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt += 7;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    else pass_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else pass_cnt++;
    if (sum_o !== 10'd0) $display("FAIL reset_sum_o: got %0d expected 0", sum_o);
    else pass_cnt++;
    if (sum_ovf !== 1'b0) $display("FAIL reset_sum_ovf: got %b expected 0", sum_ovf);
    else pass_cnt++;
    if (max_o !== 5'd0) $display("FAIL reset_max_o: got %0d expected 0", max_o);
    else pass_cnt++;
    if (pow_cnt !== 5'd0 || mismatch_cnt !== 5'd0)
      $display("FAIL reset_counts: got pow %0d mis %0d expected 0 0", pow_cnt, mismatch_cnt);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Sends the current sample list and compares the summary with the model, then acknowledges.
  task automatic test_frame(input string name, input int gap_mode);
    bit to, early;
    int e_sum, e_ovf, e_max, e_pow, e_mis;
    model(16, 10, e_sum, e_ovf, e_max, e_pow, e_mis);
    send_frame(16, gap_mode, to, early);
    chk_cnt += 9;
    if (to || early) $display("FAIL %s_timing: got timeout %b early %b expected 0 0", name, to, early);
    else pass_cnt++;
    if (out_valid !== 1'b1) $display("FAIL %s_latency: got out_valid %b expected 1", name, out_valid);
    else pass_cnt++;
    if (in_ready !== 1'b0) $display("FAIL %s_in_ready: got %b expected 0", name, in_ready);
    else pass_cnt++;
    if (sum_o !== 10'(e_sum)) $display("FAIL %s_sum_o: got %0d expected %0d", name, sum_o, e_sum);
    else pass_cnt++;
    if (sum_ovf !== 1'(e_ovf)) $display("FAIL %s_sum_ovf: got %b expected %0d", name, sum_ovf, e_ovf);
    else pass_cnt++;
    if (max_o !== 5'(e_max)) $display("FAIL %s_max_o: got %0d expected %0d", name, max_o, e_max);
    else pass_cnt++;
    if (pow_cnt !== 5'(e_pow)) $display("FAIL %s_pow_cnt: got %0d expected %0d", name, pow_cnt, e_pow);
    else pass_cnt++;
`ifdef EX1_ACC_CHECK_EN
    if (mismatch_cnt !== 5'(e_mis))
      $display("FAIL %s_mismatch_cnt: got %0d expected %0d", name, mismatch_cnt, e_mis);
    else pass_cnt++;
`else
    chk_cnt--;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_release: got out_valid %b busy %b expected 0 0", name, out_valid, busy);
    else pass_cnt++;
    chk_cnt++;
    if (sum_o !== 10'(e_sum)) $display("FAIL %s_idle_hold: got %0d expected %0d", name, sum_o, e_sum);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    fill_sweep();
    test_frame("sweep", 0);
  endtask

  task automatic test_gaps();
    fill_sweep();
    test_frame("gaps", 1);
  endtask

  task automatic test_checker();
    fill_sweep();
    so[10] = 3;  // {x,y}={2,2} should give 4
    test_frame("checker", 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) begin
        sx[i] = int'($urandom_range(0, 3));
        sy[i] = ($urandom_range(0, 2) == 0) ? sx[i] : int'($urandom_range(0, 3));
        so[i] = ((sx[i] == sy[i]) ? sx[i] ** sy[i] : sx[i] * sy[i]) % 32;
        if ($urandom_range(0, 3) == 0) so[i] = int'($urandom_range(0, 31));
      end
      test_frame("random", 2);
    end
  endtask

  task automatic test_backpressure();
    bit to, early;
    fill_sweep();
    send_frame(16, 0, to, early);
    for (int c = 0; c < 5; c++) begin
      chk_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum_o !== 10'd55 || max_o !== 5'd27)
        $display("FAIL bp_hold: got valid %b ready %b sum %0d max %0d expected 1 0 55 27",
                 out_valid, in_ready, sum_o, max_o);
      else pass_cnt++;
      start = (c == 2);
      @(negedge clk);
      start = 1'b0;
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_release: got out_valid %b busy %b expected 0 0", out_valid, busy);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL bp_start_ignored: got busy %b expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit to, early;
    fill_sweep();
    send_frame(7, 0, to, early);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sum_o !== 10'd0 || max_o !== 5'd0 ||
        pow_cnt !== 5'd0 || sum_ovf !== 1'b0)
      $display("FAIL mid_reset: got busy %b valid %b sum %0d max %0d pow %0d ovf %b expected zeros",
               busy, out_valid, sum_o, max_o, pow_cnt, sum_ovf);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL mid_no_summary: got %b expected 0", out_valid);
    else pass_cnt++;
    test_frame("after_reset", 0);
  endtask

  task automatic test_overflow();
    int n = 0;
    int cyc = 0;
    int total = 4 * 27;
    o_start = 1'b1;
    @(negedge clk);
    o_start = 1'b0;
    o_x = 2'd3;
    o_y = 2'd3;
    o_o = 5'd27;
    o_in_valid = 1'b1;
    while (n < 4 && cyc < 50) begin
      if (o_in_ready) n++;
      @(negedge clk);
      cyc++;
    end
    o_in_valid = 1'b0;
    chk_cnt += 2;
    if (o_out_valid !== 1'b1) $display("FAIL ovf_valid: got %b expected 1", o_out_valid);
    else pass_cnt++;
    if (o_sum !== 5'(total % 32) || o_ovf !== 1'b1 || o_max !== 5'd27 || o_pow !== 3'd4 ||
        o_mis !== 3'd0)
      $display("FAIL ovf_summary: got sum %0d ovf %b max %0d pow %0d mis %0d expected %0d 1 27 4 0",
               o_sum, o_ovf, o_max, o_pow, o_mis, total % 32);
    else pass_cnt++;
    o_out_ready = 1'b1;
    @(negedge clk);
    o_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_gaps();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_checker();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ex1_result_acc.md
Name: ex1_result_acc

Overview:
- Downstream consumer of the x/y power-or-product unit.
- Collects a frame of NUM_SAMPLES result samples (x, y, o) over a valid/ready stream.
- Accumulates per frame: sum of o, maximum o, count of power-mode samples (x==y).
- Presents the frame summary on a held output with a valid/ready handshake.

Parameters:
- NUM_SAMPLES, 16, samples per frame (>=1).
- SUM_W, 10, width of running sum of o.
- CNT_W, 5, width of sample/event counters; must hold NUM_SAMPLES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  pulse; begins a frame when in IDLE.
- in_valid  input  1  sample valid.
- in_ready  output  1  block accepts a sample.
- in_x  input  2  x operand of sample.
- in_y  input  2  y operand of sample.
- in_o  input  5  result o of sample.
- out_valid  output  1  frame summary valid.
- out_ready  input  1  consumer takes summary.
- sum_o  output  SUM_W  sum of o over frame, modulo 2^SUM_W.
- sum_ovf  output  1  sticky: sum wrapped during frame.
- max_o  output  5  largest o in frame.
- pow_cnt  output  CNT_W  samples with in_x==in_y.
- busy  output  1  state != IDLE.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE; sum_o, sum_ovf, max_o, pow_cnt, sample counter all 0; in_ready=0; out_valid=0; busy=0.
- Reset mid-frame or mid-DONE aborts immediately; no summary is produced.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 -> clear all accumulators and the counter; next state ACCUM.
  - Samples are not accepted.
  - Previous summary outputs stay readable until start.
- ACCUM:
  - in_ready=1 combinationally from state.
  - Transfer = in_valid && in_ready.
  - On each transfer:
    - sum_o += zero-extended in_o.
    - sum_ovf |= carry out.
    - max_o = max(max_o, in_o).
    - pow_cnt += (in_x==in_y).
    - counter++.
  - On the transfer that makes counter==NUM_SAMPLES: next state DONE, registered, so out_valid rises the following cycle.
  - No transfer -> hold.
  - start is ignored.
- DONE:
  - out_valid=1; in_ready=0; outputs stable.
  - out_ready=1 -> next state IDLE, out_valid drops next cycle.
  - start is ignored; start in the same cycle as the out_ready handshake is ignored.
- Latency: summary valid exactly 1 cycle after the last accepted sample.
- Arithmetic is unsigned throughout. Counters do not wrap within a legal frame.

Optional Feature:
- Macro: EX1_ACC_CHECK_EN.
- Defined:
  - Adds output mismatch_cnt [CNT_W].
  - Each transfer recomputes expected = (x==y) ? x**y : x*y, 5-bit, with 0**0 = 1.
  - Increments mismatch_cnt when expected != in_o.
  - Cleared on reset and on start; held through DONE and IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package ex1_pkg holds:
  - state enum (IDLE, ACCUM, DONE);
  - constants X_W=2, O_W=5;
  - function exp_result(x, y) implementing the reference power/product rule.
- One natural sub-module, ex1_ref_model: combinational expected-result generator. Instantiated only under EX1_ACC_CHECK_EN.

Test Plan:
- Full sweep, default params:
  - Stimulus: start, then 16 samples {x,y}=0..15 with correct o, in_valid held high.
  - Response: out_valid 1 cycle after 16th transfer; sum_o=55, sum_ovf=0, max_o=27, pow_cnt=4 (mismatch_cnt=0 if enabled).
- Input gaps:
  - Stimulus: same sweep with in_valid low every other cycle.
  - Response: identical summary; counter advances only on transfers.
- Output backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE; pulse start during the wait.
  - Response: outputs stable, in_ready=0, start ignored; IDLE one cycle after out_ready=1.
- Overflow:
  - Stimulus: SUM_W=5, NUM_SAMPLES=4, four samples x=y=3, o=27.
  - Response: sum_o=12 (108 mod 32), sum_ovf=1, max_o=27, pow_cnt=4.
- Reset mid-frame:
  - Stimulus: rst after 7 samples, then start and a fresh sweep.
  - Response: immediate IDLE, all outputs 0, no out_valid; new frame yields sum_o=55.
- Checker (EX1_ACC_CHECK_EN):
  - Stimulus: sweep with sample x=2, y=2 sent as o=3.
  - Response: mismatch_cnt=1, sum_o=54.
